// File: rtl/xil_fifo_pkg.sv
// Shared helpers for the narrow-to-wide FIFO: ceiling log2, lane-index
// width and the elaboration-time parameter legality check.
package xil_fifo_pkg;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int lane_w(input int ratio);
    return (ratio > 1) ? clog2(ratio) : 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // RATIO must be 2, 4 or 8; DEPTH a power of two of at least 2.
  function automatic bit params_ok(input int ratio, input int depth);
    return is_pow2(ratio) && (ratio >= 2) && (ratio <= 8) &&
           is_pow2(depth) && (depth >= 2);
  endfunction

endpackage

// File: rtl/xil_fifo_n2w_if.sv
// Narrow write / wide read handshake bundle of xil_fifo_n2w.
// o_level exists only when XIL_FIFO_N2W_LEVEL_EN is defined.
interface xil_fifo_n2w_if
  import xil_fifo_pkg::*;
#(
  parameter int NARROW_W = 16,
  parameter int RATIO    = 2,
  parameter int DEPTH    = 512
);
  logic                      i_wr_valid;
  logic                      o_wr_ready;
  logic [NARROW_W-1:0]       i_wr_data;
  logic                      i_flush;
  logic                      o_rd_valid;
  logic                      i_rd_ready;
  logic [NARROW_W*RATIO-1:0] o_rd_data;
`ifdef XIL_FIFO_N2W_LEVEL_EN
  logic [clog2(DEPTH+2)-1:0] o_level;
`endif

  modport slave (
    input  i_wr_valid, i_wr_data, i_flush, i_rd_ready,
    output o_wr_ready, o_rd_valid, o_rd_data
`ifdef XIL_FIFO_N2W_LEVEL_EN
    , output o_level
`endif
  );

  modport master (
    output i_wr_valid, i_wr_data, i_flush, i_rd_ready,
    input  o_wr_ready, o_rd_valid, o_rd_data
`ifdef XIL_FIFO_N2W_LEVEL_EN
    , input o_level
`endif
  );
endinterface

// File: rtl/xil_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, one clock.
// No reset on the array or read register so it maps onto block RAM.
module xil_sdp_ram
  import xil_fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             re,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Synchronous read port; holds its value while re is low
  always_ff @(posedge clk) begin
    if (re) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/xil_fifo_n2w.sv
// Narrow-to-wide packing FIFO. The first narrow word of a wide word lands
// in the most significant lane. The RAM read register doubles as the output
// register, so o_rd_data is masked to zero while o_rd_valid is low.
// Optional macro XIL_FIFO_N2W_LEVEL_EN adds the o_level occupancy port.
module xil_fifo_n2w
  import xil_fifo_pkg::*;
#(
  parameter int NARROW_W = 16,
  parameter int RATIO    = 2,
  parameter int DEPTH    = 512
) (
  input logic           clk,
  input logic           rst,
  xil_fifo_n2w_if.slave bus
);
  localparam int WIDE_W = NARROW_W * RATIO;
  localparam int PACK_W = NARROW_W * (RATIO - 1);
  localparam int LANE_W = lane_w(RATIO);
  localparam int AW     = clog2(DEPTH);
  localparam int CNT_W  = clog2(DEPTH + 1);

  if (!params_ok(RATIO, DEPTH)) begin : g_param_err
    $error("xil_fifo_n2w: RATIO must be 2/4/8 and DEPTH a power of two >= 2");
  end

  logic [LANE_W-1:0] lane;
  logic [PACK_W-1:0] pack;
  logic [CNT_W-1:0]  count;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              rd_vld_p1;
  logic [WIDE_W-1:0] ram_q_p1;
  logic [WIDE_W-1:0] merged;
  logic              wr_ready, wr_acc, flush_acc, last_lane, commit, rd_en;

  assign wr_ready  = (count != CNT_W'(DEPTH));
  assign wr_acc    = bus.i_wr_valid & wr_ready;
  assign flush_acc = bus.i_flush & wr_ready;
  assign last_lane = (lane == LANE_W'(RATIO - 1));
  // A flush with nothing buffered and no write is a no-op.
  assign commit    = (wr_acc & last_lane) |
                     (flush_acc & ((lane != '0) | wr_acc));
  assign rd_en     = (count != '0) & (~rd_vld_p1 | bus.i_rd_ready);

  // Pack register plus the incoming word placed in its lane; unfilled lanes zero
  always_comb begin
    merged = {pack, {NARROW_W{1'b0}}};
    if (wr_acc) merged[(RATIO - int'(lane)) * NARROW_W - 1 -: NARROW_W] = bus.i_wr_data;
  end

  // Pack stage: lane index and partially filled upper lanes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane <= '0;
      pack <= '0;
    end else if (commit) begin
      lane <= '0;
      pack <= '0;
    end else if (wr_acc) begin
      lane <= lane + LANE_W'(1);
      pack <= merged[WIDE_W-1 -: PACK_W];
    end
  end

  // Storage pointers and occupancy count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (commit) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en)  rd_ptr <= rd_ptr + AW'(1);
      case ({commit, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  xil_sdp_ram #(
    .WIDTH (WIDE_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we      (commit),
    .wr_addr (wr_ptr),
    .wr_data (merged),
    .re      (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (ram_q_p1)
  );

  // Output stage valid: set by a RAM read, cleared by a pop without refill
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 rd_vld_p1 <= 1'b0;
    else if (rd_en)          rd_vld_p1 <= 1'b1;
    else if (bus.i_rd_ready) rd_vld_p1 <= 1'b0;
  end

  assign bus.o_wr_ready = wr_ready;
  assign bus.o_rd_valid = rd_vld_p1;
  assign bus.o_rd_data  = rd_vld_p1 ? ram_q_p1 : '0;

`ifdef XIL_FIFO_N2W_LEVEL_EN
  localparam int LVL_W = clog2(DEPTH + 2);
  assign bus.o_level = LVL_W'(count) + LVL_W'(rd_vld_p1);
`endif
endmodule

// File: tb/tb_xil_fifo_n2w.sv
// Directed bench for xil_fifo_n2w with a scoreboard of expected wide words.
// Two instances: RATIO=2/NARROW_W=16 and RATIO=4/NARROW_W=8, both DEPTH=4.
module tb_xil_fifo_n2w;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xil_fifo_n2w_if #(.NARROW_W(16), .RATIO(2), .DEPTH(4)) b2 ();
  xil_fifo_n2w_if #(.NARROW_W(8),  .RATIO(4), .DEPTH(4)) b4 ();

  xil_fifo_n2w #(.NARROW_W(16), .RATIO(2), .DEPTH(4)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  xil_fifo_n2w #(.NARROW_W(8),  .RATIO(4), .DEPTH(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

  logic [31:0] q2[$];
  logic [31:0] q4[$];
  int n_checks = 0;
  int n_fail   = 0;
  int pops2    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score any transfer happening at the coming edge, then step past it.
  task automatic tick();
    @(negedge clk);
    if (b2.o_rd_valid === 1'b1 && b2.i_rd_ready === 1'b1) begin
      pops2++;
      n_checks++;
      assert (q2.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected_r2 observed=%0h expected=none", b2.o_rd_data);
      end
      if (q2.size() != 0) check("sb_data_r2", b2.o_rd_data, q2.pop_front());
    end
    if (b4.o_rd_valid === 1'b1 && b4.i_rd_ready === 1'b1) begin
      n_checks++;
      assert (q4.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected_r4 observed=%0h expected=none", b4.o_rd_data);
      end
      if (q4.size() != 0) check("sb_data_r4", b4.o_rd_data, q4.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 40 && (q2.size() != 0 || q4.size() != 0); k++) tick();
    check(tag, q2.size() + q4.size(), 0);
  endtask

  initial begin
    b2.i_wr_valid = 0; b2.i_wr_data = '0; b2.i_flush = 0; b2.i_rd_ready = 0;
    b4.i_wr_valid = 0; b4.i_wr_data = '0; b4.i_flush = 0; b4.i_rd_ready = 0;
    repeat (2) tick();
    check("rst_wr_ready", b2.o_wr_ready, 1);
    check("rst_rd_valid", b2.o_rd_valid, 0);
    check("rst_rd_data",  b2.o_rd_data,  0);
    check("rst_rd_valid_r4", b4.o_rd_valid, 0);
`ifdef XIL_FIFO_N2W_LEVEL_EN
    check("rst_level", b2.o_level, 0);
`endif
    rst = 0;
    tick();

    // Basic pack and latency
    b2.i_rd_ready = 1;
    b2.i_wr_valid = 1; b2.i_wr_data = 16'h1111; tick();
    b2.i_wr_data = 16'h2222; q2.push_back(32'h1111_2222); tick();
    b2.i_wr_valid = 0;
    check("lat_t1_valid", b2.o_rd_valid, 0);
    tick();
    check("lat_t2_valid", b2.o_rd_valid, 1);
    check("lat_t2_data",  b2.o_rd_data, 32'h1111_2222);
    tick();
    check("single_cycle", b2.o_rd_valid, 0);

    // Flush of a partial word, then a no-op flush
    b2.i_wr_valid = 1; b2.i_wr_data = 16'hAAAA; tick();
    b2.i_wr_valid = 0;
    repeat (3) tick();
    b2.i_flush = 1; q2.push_back(32'hAAAA_0000); tick();
    b2.i_flush = 0;
    drain("drain_flush");
    b2.i_flush = 1; tick();
    b2.i_flush = 0;
    repeat (4) tick();
    check("flush_noop_valid", b2.o_rd_valid, 0);

    // Fill to DEPTH+1 wide words with the consumer stalled
    b2.i_rd_ready = 0;
    for (int i = 1; i <= 10; i++) begin
      b2.i_wr_valid = 1; b2.i_wr_data = 16'(i);
      check("fill_ready", b2.o_wr_ready, 1);
      if (i % 2 == 0) q2.push_back({16'(i - 1), 16'(i)});
      tick();
    end
    check("full_ready", b2.o_wr_ready, 0);
`ifdef XIL_FIFO_N2W_LEVEL_EN
    check("full_level", b2.o_level, 5);
`endif
    b2.i_wr_data = 16'd11;
    repeat (2) tick();
    check("full_hold_ready", b2.o_wr_ready, 0);
    check("full_hold_data",  b2.o_rd_data, 32'h0001_0002);
    b2.i_rd_ready = 1; tick();
    b2.i_rd_ready = 0;
    check("refill_ready", b2.o_wr_ready, 1);
    tick();
    b2.i_wr_data = 16'd12; q2.push_back(32'h000B_000C); tick();
    b2.i_wr_valid = 0; b2.i_rd_ready = 1;
    drain("drain_full");

    // Continuous streaming through pointer wrap
    pops2 = 0;
    for (int i = 0; i < 40; i++) begin
      b2.i_wr_valid = 1; b2.i_wr_data = 16'h0100 + 16'(i);
      if (i % 2 == 1) q2.push_back({16'h0100 + 16'(i - 1), 16'h0100 + 16'(i)});
      tick();
    end
    b2.i_wr_valid = 0;
    drain("drain_stream");
    check("stream_pops", pops2, 20);

    // Reset mid-operation discards everything including the partial word
    b2.i_rd_ready = 0;
    b2.i_wr_valid = 1;
    b2.i_wr_data = 16'h0101; tick();
    b2.i_wr_data = 16'h0202; tick();
    b2.i_wr_data = 16'h0303; tick();
    b2.i_wr_valid = 0;
    rst = 1; tick();
    check("mid_rst_wr_ready", b2.o_wr_ready, 1);
    check("mid_rst_rd_valid", b2.o_rd_valid, 0);
    check("mid_rst_rd_data",  b2.o_rd_data, 0);
`ifdef XIL_FIFO_N2W_LEVEL_EN
    check("mid_rst_level", b2.o_level, 0);
`endif
    rst = 0; q2.delete(); tick();
    b2.i_rd_ready = 1;
    b2.i_wr_valid = 1; b2.i_wr_data = 16'hBEEF; tick();
    b2.i_wr_data = 16'hCAFE; q2.push_back(32'hBEEF_CAFE); tick();
    b2.i_wr_valid = 0;
    drain("drain_post_rst");

    // RATIO=4 packing and write-with-flush
    b4.i_rd_ready = 1;
    b4.i_wr_valid = 1;
    b4.i_wr_data = 8'h11; tick();
    b4.i_wr_data = 8'h22; tick();
    b4.i_wr_data = 8'h33; tick();
    b4.i_wr_data = 8'h44; q4.push_back(32'h1122_3344); tick();
    b4.i_wr_data = 8'h55; b4.i_flush = 1; q4.push_back(32'h5500_0000); tick();
    b4.i_wr_valid = 0; b4.i_flush = 0;
    drain("drain_r4");
    check("r4_idle_valid", b4.o_rd_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/xil_fifo_n2w.md
# xil_fifo_n2w

Single-clock, width-converting FIFO. It accepts a stream of narrow words and delivers packed wide words through a valid/ready handshake. Depth, narrow width and pack ratio are parameters, and a flush input pads and commits a partial wide word. It sits between narrow producers (16-bit packet datapaths) and wide consumers (32/64-bit memory or NoC interfaces), replacing fixed asymmetric dual-port memories wherever flow control is needed.

## Interface
- NARROW_W, 16, narrow word width in bits.
- RATIO, 2, narrow words per wide word; power of two in {2, 4, 8}.
- DEPTH, 512, wide-word entries in storage RAM; power of two, ≥ 2.
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- i_wr_valid  in  1  narrow word present.
- o_wr_ready  out  1  narrow word / flush can be accepted.
- i_wr_data  in  NARROW_W  narrow word.
- i_flush  in  1  commit current partial wide word, unfilled lanes zero.
- o_rd_valid  out  1  wide word present on o_rd_data.
- i_rd_ready  in  1  consumer accepts wide word.
- o_rd_data  out  NARROW_W*RATIO  wide word.
- o_level  out  clog2(DEPTH+2)  wide words held (only with XIL_FIFO_N2W_LEVEL_EN).

## Operation
- Lane order: first narrow word of a wide word occupies the most significant lane, [W*RATIO-1 -: W]. The last word occupies [W-1:0].
- Pack stage: lane index register (0..RATIO-1) plus a pack register of RATIO-1 lanes.
  - Write is accepted when i_wr_valid & o_wr_ready.
  - On the accepted write with lane index RATIO-1, the pack register merged with i_wr_data is written to RAM at the same edge. Lane index returns to 0.
- Flush is honoured only when o_wr_ready = 1.
  - If lane index ≠ 0, or a write is accepted in the same cycle, the partial word is committed with unfilled lanes zero and lane index returns to 0.
  - A flush combined with the write that fills the last lane equals a plain write.
  - A flush with lane index 0 and no write is a no-op.
- Storage: DEPTH-entry RAM with write/read pointers wrapping modulo DEPTH and a count register 0..DEPTH.
- o_wr_ready = (count != DEPTH), independent of lane index.
- Output stage: one wide output register with a valid flag. Total capacity is DEPTH+1 wide words.
  - A RAM read is issued when count ≠ 0 and the output register is empty or being popped (o_rd_valid & i_rd_ready).
  - Read data loads the output register at the next edge.
- A simultaneous RAM write and RAM read leaves count unchanged. Pointers advance independently.
- Reset, including mid-operation, clears pointers, count, lane index, pack register and output valid. RAM contents are not cleared. Any partial word is discarded.

## Timing
- Reset values:
  - o_wr_ready = 1.
  - o_rd_valid = 0.
  - o_rd_data = 0.
  - o_level = 0.
- Latency: with the FIFO empty, the write filling the last lane is accepted in cycle t and o_rd_valid rises in cycle t+2. A flush has the same latency.
- Throughput: one narrow word per cycle in; one wide word per cycle out while data is available.
- o_rd_data is held stable while o_rd_valid = 1 and i_rd_ready = 0.
- Full → not full: o_wr_ready rises in the cycle after the RAM read that drains an entry.

## Configuration
- XIL_FIFO_N2W_LEVEL_EN defined: o_level port exists. It equals RAM count plus output valid, updated on every edge and reset to 0.
- Undefined: the port and its counter logic are absent. All other behaviour is identical.

## Structure
- Shared package xil_fifo_pkg: clog2 function, lane-index width derivation, and elaboration-time parameter checks (RATIO a power of two, DEPTH ≥ 2).
- Sub-module xil_sdp_ram: simple dual-port RAM (one write port, one synchronous read port, single clock), parametrised in width and depth, inferring block RAM.

## Test plan
All scenarios use NARROW_W=16, RATIO=2, DEPTH=4 unless stated.
- Write 0x1111 then 0x2222 in consecutive cycles, i_rd_ready=1 → o_rd_valid high two cycles after second write; o_rd_data = 0x11112222 for one cycle.
- Write 0xAAAA, idle 3 cycles, pulse i_flush → o_rd_data = 0xAAAA0000. A flush with lane index 0 produces no output.
- 12 writes (0x0001..0x000C) with i_rd_ready=0 → 5 wide words held and o_wr_ready low after the 10th write. The 11th word is not accepted until one pop; o_level = 5 with the macro.
- Steady state with i_rd_ready=1 and continuous writes → one wide word every two cycles, no gaps or duplicates, pointers wrap past DEPTH.
- Assert rst for one cycle after 3 narrow writes → all outputs return to reset values. Subsequent writes 0xBEEF, 0xCAFE → 0xBEEFCAFE.
- RATIO=4, NARROW_W=8: write 0x11, 0x22, 0x33, 0x44 → 0x11223344. Write 0x55 + flush → 0x55000000.
